// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - default 640x480 raster timing and frame sequencer state type
package video_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    typedef enum logic [1:0] {
        RUN,
        START,
        COPY,
        RESUME
    } frame_state_t;

endpackage

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster counters with registered sync/enable decode
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter bit SYNC_POL    = 1'b0,
    parameter int COORD_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [COORD_WIDTH-1:0] hpos,
    output logic [COORD_WIDTH-1:0] vpos,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   display_on,
    output logic                   vs_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_WIDTH-1:0] H_LAST  = COORD_WIDTH'(H_TOTAL - 1);
    localparam logic [COORD_WIDTH-1:0] V_LAST  = COORD_WIDTH'(V_TOTAL - 1);
    localparam logic [COORD_WIDTH-1:0] H_VIS   = COORD_WIDTH'(H_ACTIVE);
    localparam logic [COORD_WIDTH-1:0] V_VIS   = COORD_WIDTH'(V_ACTIVE);
    localparam logic [COORD_WIDTH-1:0] HS_BEG  = COORD_WIDTH'(H_ACTIVE + H_FRONT);
    localparam logic [COORD_WIDTH-1:0] HS_END  = COORD_WIDTH'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [COORD_WIDTH-1:0] VS_BEG  = COORD_WIDTH'(V_ACTIVE + V_FRONT);
    localparam logic [COORD_WIDTH-1:0] VS_END  = COORD_WIDTH'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [COORD_WIDTH-1:0] h_next;
    logic [COORD_WIDTH-1:0] v_next;

    always_comb begin
        h_next = hpos + COORD_WIDTH'(1);
        v_next = vpos;
        if (hpos == H_LAST) begin
            h_next = '0;
            v_next = (vpos == V_LAST) ? '0 : vpos + COORD_WIDTH'(1);
        end
    end

    // Decode the next position so the sync/enable flops line up with hpos/vpos.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hpos       <= '0;
            vpos       <= '0;
            hsync      <= ~SYNC_POL;
            vsync      <= ~SYNC_POL;
            display_on <= 1'b0;
        end else begin
            hpos       <= h_next;
            vpos       <= v_next;
            hsync      <= (h_next >= HS_BEG && h_next < HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync      <= (v_next >= VS_BEG && v_next < VS_END) ? SYNC_POL : ~SYNC_POL;
            display_on <= (h_next < H_VIS) && (v_next < V_VIS);
        end
    end

    assign vs_start = (hpos == '0) && (vpos == VS_BEG);

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - raster timing plus per-frame vblank copy/resume sequencing
module frame_sequencer
    import video_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter bit SYNC_POL    = 1'b0,
    parameter int COORD_WIDTH = 10,
    parameter int COPY_CYCLES = 1024,
    parameter int PIPE_DELAY  = 2,
    parameter bit DROP_MODE   = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_wait,
    output logic [COORD_WIDTH-1:0] hpos,
    output logic [COORD_WIDTH-1:0] vpos,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   display_on,
    output logic                   hsync_d,
    output logic                   vsync_d,
    output logic                   display_on_d,
    output logic                   copy_start,
    output logic                   gpu_reset,
    output logic                   resume,
    output logic                   copy,
    output logic                   overrun,
    output logic [15:0]            frame_count,
    output logic [15:0]            drop_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [15:0] COPY_LOAD = 16'(COPY_CYCLES - 1);
    localparam logic [2:0]  IDLE_TAP  = {~SYNC_POL, ~SYNC_POL, 1'b0};

    if (COPY_CYCLES < 1 || COPY_CYCLES > 65536 || COPY_CYCLES + 2 >= H_TOTAL * V_TOTAL) begin : g_bad_copy_cycles
        $error("frame_sequencer: COPY_CYCLES out of range for this raster");
    end

    logic         vs_start;
    frame_state_t state;
    logic [15:0]  copy_left;
    logic [2:0]   tap_in;

    video_timing_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .H_FRONT     (H_FRONT),
        .H_SYNC      (H_SYNC),
        .H_BACK      (H_BACK),
        .V_ACTIVE    (V_ACTIVE),
        .V_FRONT     (V_FRONT),
        .V_SYNC      (V_SYNC),
        .V_BACK      (V_BACK),
        .SYNC_POL    (SYNC_POL),
        .COORD_WIDTH (COORD_WIDTH)
    ) u_timing (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .hsync      (hsync),
        .vsync      (vsync),
        .display_on (display_on),
        .vs_start   (vs_start)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            copy_left   <= '0;
            copy_start  <= 1'b0;
            gpu_reset   <= 1'b0;
            resume      <= 1'b0;
            copy        <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            copy_start <= 1'b0;
            gpu_reset  <= 1'b0;
            resume     <= 1'b0;
            case (state)
                RUN: begin
                    if (vs_start) begin
                        if (cpu_wait || !DROP_MODE) begin
                            state      <= START;
                            copy_start <= 1'b1;
                            gpu_reset  <= 1'b1;
                            copy       <= 1'b1;
                            copy_left  <= COPY_LOAD;
                            if (!cpu_wait) overrun <= 1'b1;
                        end else begin
                            drop_count <= drop_count + 16'd1;
                        end
                    end
                end
                START, COPY: begin
                    if (vs_start) drop_count <= drop_count + 16'd1;
                    // copy_left counts the copy cycles still owed after this one.
                    if (copy_left == '0) begin
                        state       <= RESUME;
                        copy        <= 1'b0;
                        resume      <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                    end else begin
                        state     <= COPY;
                        copy_left <= copy_left - 16'd1;
                    end
                end
                RESUME: begin
                    if (vs_start) drop_count <= drop_count + 16'd1;
                    state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign tap_in = {hsync, vsync, display_on};

    if (PIPE_DELAY == 0) begin : g_pass
        assign {hsync_d, vsync_d, display_on_d} = tap_in;
    end else begin : g_pipe
        for (genvar i = 0; i < PIPE_DELAY; i++) begin : g_stage
            logic [2:0] d;
            logic [2:0] q;
            if (i == 0) begin : g_src
                assign d = tap_in;
            end else begin : g_src
                assign d = g_stage[i-1].q;
            end
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) q <= IDLE_TAP;
                else        q <= d;
            end
        end
        assign {hsync_d, vsync_d, display_on_d} = g_stage[PIPE_DELAY-1].q;
    end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Parametrised successor to the fixed 640x480 timing and frame-control logic. It generates raster timing for any resolution and sequences the per-frame vblank handshake between CPU, button/rect copy engines and GPU: copy_start, copy, resume and gpu_reset. New behaviour: CPU-overrun detection with optional frame drop, frame/drop counters, and a configurable sync/enable delay line matching GPU pixel latency.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths
- V_ACTIVE, 480, visible lines
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths
- SYNC_POL, 0, sync active level; 0 = active-low
- COORD_WIDTH, 10, width of hpos/vpos
- COPY_CYCLES, 1024, cycles `copy` stays high per accepted frame; 1..2^16
- PIPE_DELAY, 2, delay stages on the `_d` outputs; 0 = passthrough
- DROP_MODE, 1, 1 = skip the frame if the CPU is not waiting; 0 = copy anyway and flag overrun

Ports:
- clk  in  1  system pixel clock
- reset  in  1  one clock; reset is asynchronous and active-low
- cpu_wait  in  1  CPU has finished its frame and waits for resume
- hpos, vpos  out  COORD_WIDTH  raster position
- hsync, vsync, display_on  out  1  decoded from current hpos/vpos
- hsync_d, vsync_d, display_on_d  out  1  the above delayed PIPE_DELAY cycles
- copy_start, gpu_reset, resume  out  1  single-cycle pulses
- copy  out  1  memory-bus select for copy engines
- overrun  out  1  sticky; CPU was not waiting at an accepted frame (DROP_MODE=0)
- frame_count, drop_count  out  16  accepted / dropped frames, wrap at 2^16

## Operation
- H_TOTAL = sum of H params; V_TOTAL likewise. hpos counts 0..H_TOTAL-1, then wraps to 0 and vpos increments. vpos wraps V_TOTAL-1 -> 0.
- hsync is active when H_ACTIVE+H_FRONT <= hpos < H_ACTIVE+H_FRONT+H_SYNC. vsync uses the same rule on vpos. display_on = (hpos<H_ACTIVE)&&(vpos<V_ACTIVE).
- vs_start is an internal pulse when hpos==0 and vpos==V_ACTIVE+V_FRONT.
- FSM states: RUN, START, COPY, RESUME. Reset state is RUN.
- RUN, on vs_start:
  - If cpu_wait=1 or DROP_MODE=0: go to START. If DROP_MODE=0 and cpu_wait=0, also set overrun.
  - Otherwise: drop_count++ and stay in RUN.
- START, 1 cycle: copy_start=1, gpu_reset=1, copy=1. Load the copy counter with COPY_CYCLES-1.
- COPY: copy=1. The counter decrements each cycle; at 0, go to RESUME.
- RESUME, 1 cycle: resume=1, copy=0, frame_count++. Next state is RUN.
- A vs_start arriving outside RUN is ignored and increments drop_count.
- overrun clears only on reset.

## Timing
- Reset values: hpos=vpos=0; all syncs and `_d` syncs at the inactive level (!SYNC_POL); display_on, display_on_d, all pulses, copy, overrun=0; counters=0.
- All outputs are registered, and hsync/vsync/display_on are coincident with hpos/vpos. The first edge after reset release gives hpos=1, so pixel (0,0) of the first frame is blanked.
- If vs_start is at cycle T: copy_start and gpu_reset are at T+1; copy is high during T+1..T+COPY_CYCLES; resume is at T+COPY_CYCLES+1.
- `_d` outputs lag by exactly PIPE_DELAY cycles. Each delay stage resets to the inactive value.
- Reset asserted mid-COPY: copy drops immediately (asynchronously), no resume is issued, FSM returns to RUN.
- Elaboration check: COPY_CYCLES+2 < H_TOTAL*V_TOTAL.

## Structure
- Package video_pkg holds:
  - default 640x480 timing constants
  - the FSM state enum typedef frame_state_t {RUN, START, COPY, RESUME}
- Sub-module video_timing_gen: counters plus sync/enable decode, with the H/V/SYNC_POL/COORD_WIDTH parameters.
- frame_sequencer contains the FSM, the counters, and the delay line, built as a generate loop of PIPE_DELAY register stages.

## Test plan
- Bench params for all scenarios: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), COPY_CYCLES=5, PIPE_DELAY=2.
- Reset release: hpos steps 1..13 -> 0 and vpos increments; hsync low exactly at hpos 10..11; display_on=0 for hpos>=8 or vpos>=4.
- cpu_wait=1 held: vsync falls at (0,5); copy_start+gpu_reset one cycle later; copy high 5 cycles; resume next cycle; frame_count=1 after frame 1, 3 after frame 3.
- DROP_MODE=1, cpu_wait=0 at vs_start: no copy_start, copy stays 0, drop_count=1, frame_count unchanged.
- DROP_MODE=0, cpu_wait=0: copy sequence still runs and overrun=1; overrun stays 1 when cpu_wait=1 next frame; clears only on reset.
- Reset pulsed 2 cycles into COPY: copy=0 immediately, no resume, hpos=vpos=0; next vs_start produces a full normal sequence.
- PIPE_DELAY=0 and PIPE_DELAY=3 builds: display_on_d equals display_on shifted by 0 / 3 cycles over a full frame.
